// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control slice: FSM states and preset switch codes.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PRESET_NONE = 2'b00;
    localparam logic [1:0] PRESET_15   = 2'b01;
    localparam logic [1:0] PRESET_30   = 2'b10;
    localparam logic [1:0] PRESET_45   = 2'b11;

endpackage

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce filter and a one-cycle
// pulse when the accepted level goes to pressed (low).
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // The accepted level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync2;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch/timer control: key conditioning, run/pause/done FSM, 1 Hz strobe,
// mode/preset latching, display-counter reset and alarm blink.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       sw_mode,
    input  logic [1:0] sw_preset,
    input  logic       done_time,
    output logic       one_second,
    output logic       start_clk,
    output logic       timer,
    output logic       fifteen,
    output logic       thirty,
    output logic       fortyfive,
    output logic       disp_reset,
    output logic       alarm_led
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic          start_press;
    logic          clear_press;
    logic          mode_s1;
    logic          mode_s2;
    logic [1:0]    preset_s1;
    logic [1:0]    preset_s2;
    logic [1:0]    preset_q;
    logic [TW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          post_reset;
    logic          sw_changed;

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .clk   (clk),
        .reset (reset),
        .key_n (key_start_n),
        .press (start_press)
    );

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
        .clk   (clk),
        .reset (reset),
        .key_n (key_clear_n),
        .press (clear_press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_s1   <= 1'b0;
            mode_s2   <= 1'b0;
            preset_s1 <= PRESET_NONE;
            preset_s2 <= PRESET_NONE;
        end else begin
            mode_s1   <= sw_mode;
            mode_s2   <= mode_s1;
            preset_s1 <= sw_preset;
            preset_s2 <= preset_s1;
        end
    end

    assign sw_changed = ({mode_s2, preset_s2} != {timer, preset_q});

    // Clear overrides every other event; done_time beats a start press while running.
    always_comb begin
        state_next = state;
        if (clear_press) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_press && !(timer && (preset_q == PRESET_NONE))) state_next = RUN;
                RUN:     if (done_time) state_next = DONE;
                         else if (start_press) state_next = PAUSE;
                PAUSE:   if (start_press) state_next = RUN;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            start_clk  <= 1'b0;
            one_second <= 1'b0;
            timer      <= 1'b0;
            preset_q   <= PRESET_NONE;
            fifteen    <= 1'b0;
            thirty     <= 1'b0;
            fortyfive  <= 1'b0;
            disp_reset <= 1'b1;
            alarm_led  <= 1'b0;
            presc      <= '0;
            blink_cnt  <= '0;
            post_reset <= 1'b1;
        end else begin
            state      <= state_next;
            start_clk  <= (state_next == RUN);
            one_second <= (state == RUN) && (presc == TICK_MAX);
            post_reset <= 1'b0;
            disp_reset <= post_reset | clear_press;

            if (clear_press) begin
                presc <= '0;
            end else if (state == RUN) begin
                presc <= (presc == TICK_MAX) ? '0 : presc + 1'b1;
            end

            // Switches are only tracked in IDLE; any new setting makes the display reload.
            if (state == IDLE) begin
                timer     <= mode_s2;
                preset_q  <= preset_s2;
                fifteen   <= mode_s2 && (preset_s2 == PRESET_15);
                thirty    <= mode_s2 && (preset_s2 == PRESET_30);
                fortyfive <= mode_s2 && (preset_s2 == PRESET_45);
                if (sw_changed) disp_reset <= 1'b1;
            end

            if (clear_press) begin
                alarm_led <= 1'b0;
                blink_cnt <= '0;
            end else if ((state_next == DONE) && (state != DONE)) begin
                alarm_led <= 1'b1;
                blink_cnt <= '0;
            end else if (state == DONE) begin
                if (blink_cnt == BLINK_MAX) begin
                    blink_cnt <= '0;
                    alarm_led <= ~alarm_led;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule
